// File: rtl/rfm_tracker_mb_pkg.sv
// Shared types and default sizing for the multi-bank RFM tracker.
// Build option: define RFM_DECAY_EN to age the serviced bank on RFM.
package rfm_pkg;

  localparam int NUM_BANK_D       = 4;
  localparam int NUM_BANK_BITS_D  = 2;
  localparam int NUM_ENTRY_D      = 16;
  localparam int NUM_ENTRY_BITS_D = 4;
  localparam int RFM_TH_D         = 20;
  localparam int ADDR_SIZE_D      = 18;
  localparam int CNT_SIZE_D       = 16;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    ISSUE
  } state_t;

  typedef struct packed {
    logic                   valid;
    logic [ADDR_SIZE_D-1:0] addr;
    logic [CNT_SIZE_D-1:0]  cnt;
  } entry_t;

endpackage

// File: rtl/rfm_tracker_mb_if.sv
// Command/response bundle between a memory controller and the tracker.
// Build option: RFM_DECAY_EN does not change this bundle.
interface rfm_tracker_mb_if
  import rfm_pkg::*;
#(
  parameter int NUM_BANK      = NUM_BANK_D,
  parameter int NUM_BANK_BITS = NUM_BANK_BITS_D,
  parameter int ADDR_SIZE     = ADDR_SIZE_D
);

  logic                     act_cmd;
  logic [NUM_BANK_BITS-1:0] act_bank;
  logic [ADDR_SIZE-1:0]     act_addr;
  logic                     rfm_cmd;
  logic [NUM_BANK_BITS-1:0] rfm_bank;
  logic                     nrr_cmd;
  logic [NUM_BANK_BITS-1:0] nrr_bank;
  logic [ADDR_SIZE-1:0]     nrr_addr;
  logic [NUM_BANK-1:0]      rfm_req;
  logic                     busy;
  logic                     rfm_drop;

  modport master (
    output act_cmd, act_bank, act_addr,
    output rfm_cmd, rfm_bank,
    input  nrr_cmd, nrr_bank, nrr_addr,
    input  rfm_req, busy, rfm_drop
  );

  modport slave (
    input  act_cmd, act_bank, act_addr,
    input  rfm_cmd, rfm_bank,
    output nrr_cmd, nrr_bank, nrr_addr,
    output rfm_req, busy, rfm_drop
  );

endinterface

// File: rtl/rfm_tracker_mb_bank_table.sv
// One bank's space-saving row table: hit/free/min search and update.
// Build option: RFM_DECAY_EN halves other counts on the ISSUE cycle.
module rfm_bank_table
  import rfm_pkg::*;
#(
  parameter int NUM_ENTRY      = NUM_ENTRY_D,
  parameter int NUM_ENTRY_BITS = NUM_ENTRY_BITS_D,
  parameter int ADDR_SIZE      = ADDR_SIZE_D,
  parameter int CNT_SIZE       = CNT_SIZE_D
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      act,
  input  logic [ADDR_SIZE-1:0]      act_addr,
  input  logic [NUM_ENTRY_BITS-1:0] rd_idx,
  input  logic                      issue,
  input  logic                      found,
  input  logic [NUM_ENTRY_BITS-1:0] sel_idx,
  output logic                      rd_valid,
  output logic [ADDR_SIZE-1:0]      rd_addr,
  output logic [CNT_SIZE-1:0]       rd_cnt
);

  localparam logic [CNT_SIZE-1:0] CMAX = '1;

  logic [NUM_ENTRY-1:0]      valid, valid_n;
  logic [ADDR_SIZE-1:0]      addr   [NUM_ENTRY];
  logic [ADDR_SIZE-1:0]      addr_n [NUM_ENTRY];
  logic [CNT_SIZE-1:0]       cnt    [NUM_ENTRY];
  logic [CNT_SIZE-1:0]       cnt_n  [NUM_ENTRY];
  logic                      hit, free;
  logic [NUM_ENTRY_BITS-1:0] hit_idx, free_idx, min_idx;
  logic [CNT_SIZE-1:0]       min_cnt;

  assign rd_valid = valid[rd_idx];
  assign rd_addr  = addr[rd_idx];
  assign rd_cnt   = cnt[rd_idx];

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    min_cnt  = cnt[0];
    min_idx  = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (!hit && valid[i] && addr[i] == act_addr) begin
        hit     = 1'b1;
        hit_idx = NUM_ENTRY_BITS'(i);
      end
      if (!free && !valid[i]) begin
        free     = 1'b1;
        free_idx = NUM_ENTRY_BITS'(i);
      end
      if (cnt[i] < min_cnt) begin
        min_cnt = cnt[i];
        min_idx = NUM_ENTRY_BITS'(i);
      end
    end
  end

  // Service clear lands first so a same-cycle ACT hit sees cnt=0.
  always_comb begin
    valid_n = valid;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      addr_n[i] = addr[i];
      cnt_n[i]  = cnt[i];
`ifdef RFM_DECAY_EN
      if (issue) cnt_n[i] = cnt[i] >> 1;
`endif
      if (issue && found && sel_idx == NUM_ENTRY_BITS'(i))
        cnt_n[i] = '0;
    end
    if (act) begin
      if (hit) begin
        if (cnt_n[hit_idx] != CMAX)
          cnt_n[hit_idx] = cnt_n[hit_idx] + 1'b1;
      end else if (free) begin
        valid_n[free_idx] = 1'b1;
        addr_n[free_idx]  = act_addr;
        cnt_n[free_idx]   = CNT_SIZE'(1);
      end else begin
        addr_n[min_idx] = act_addr;
        cnt_n[min_idx]  = (min_cnt == CMAX) ? CMAX
                                            : min_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid <= '0;
      for (int i = 0; i < NUM_ENTRY; i++) begin
        addr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      valid <= valid_n;
      for (int i = 0; i < NUM_ENTRY; i++) begin
        addr[i] <= addr_n[i];
        cnt[i]  <= cnt_n[i];
      end
    end
  end

endmodule

// File: rtl/rfm_tracker_mb.sv
// Multi-bank RAA tracker: per-bank tables, RFM scan and NRR issue.
// Build option: RFM_DECAY_EN ages the serviced bank on each RFM.
module rfm_tracker_mb
  import rfm_pkg::*;
#(
  parameter int NUM_BANK       = NUM_BANK_D,
  parameter int NUM_BANK_BITS  = NUM_BANK_BITS_D,
  parameter int NUM_ENTRY      = NUM_ENTRY_D,
  parameter int NUM_ENTRY_BITS = NUM_ENTRY_BITS_D,
  parameter int RFM_TH         = RFM_TH_D,
  parameter int ADDR_SIZE      = ADDR_SIZE_D,
  parameter int CNT_SIZE       = CNT_SIZE_D
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     act_cmd,
  input  logic [NUM_BANK_BITS-1:0] act_bank,
  input  logic [ADDR_SIZE-1:0]     act_addr,
  input  logic                     rfm_cmd,
  input  logic [NUM_BANK_BITS-1:0] rfm_bank,
  output logic                     nrr_cmd,
  output logic [NUM_BANK_BITS-1:0] nrr_bank,
  output logic [ADDR_SIZE-1:0]     nrr_addr,
  output logic [NUM_BANK-1:0]      rfm_req,
  output logic                     busy,
  output logic                     rfm_drop
);

  localparam logic [CNT_SIZE-1:0] TH = CNT_SIZE'(RFM_TH);
  localparam logic [NUM_ENTRY_BITS-1:0] LAST =
    NUM_ENTRY_BITS'(NUM_ENTRY - 1);

  state_t                    state;
  logic [NUM_BANK_BITS-1:0]  scan_bank;
  logic [NUM_ENTRY_BITS-1:0] idx, best_idx;
  logic [CNT_SIZE-1:0]       best_cnt;
  logic [ADDR_SIZE-1:0]      best_addr;
  logic                      found;
  logic [CNT_SIZE-1:0]       raa   [NUM_BANK];
  logic [CNT_SIZE-1:0]       raa_n [NUM_BANK];
  logic [NUM_BANK-1:0]       rd_valid;
  logic [ADDR_SIZE-1:0]      rd_addr [NUM_BANK];
  logic [CNT_SIZE-1:0]       rd_cnt  [NUM_BANK];
  logic                      cur_valid, take;
  logic [ADDR_SIZE-1:0]      cur_addr;
  logic [CNT_SIZE-1:0]       cur_cnt;

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    rfm_bank_table #(
      .NUM_ENTRY      (NUM_ENTRY),
      .NUM_ENTRY_BITS (NUM_ENTRY_BITS),
      .ADDR_SIZE      (ADDR_SIZE),
      .CNT_SIZE       (CNT_SIZE)
    ) u_tbl (
      .clk      (clk),
      .rstn     (rstn),
      .act      (act_cmd && act_bank == NUM_BANK_BITS'(b)),
      .act_addr (act_addr),
      .rd_idx   (idx),
      .issue    (state == ISSUE &&
                 scan_bank == NUM_BANK_BITS'(b)),
      .found    (found),
      .sel_idx  (best_idx),
      .rd_valid (rd_valid[b]),
      .rd_addr  (rd_addr[b]),
      .rd_cnt   (rd_cnt[b])
    );
    assign rfm_req[b] = raa[b] >= TH;
  end

  assign cur_valid = rd_valid[scan_bank];
  assign cur_addr  = rd_addr[scan_bank];
  assign cur_cnt   = rd_cnt[scan_bank];
  // Strict compare: ties keep the lower index, zero counts never win.
  assign take      = cur_valid && cur_cnt > best_cnt;

  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      raa_n[b] = raa[b];
      if (state == IDLE && rfm_cmd &&
          rfm_bank == NUM_BANK_BITS'(b))
        raa_n[b] = (raa[b] >= TH) ? raa[b] - TH : '0;
      if (act_cmd && act_bank == NUM_BANK_BITS'(b) &&
          raa_n[b] != '1)
        raa_n[b] = raa_n[b] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      scan_bank <= '0;
      idx       <= '0;
      best_idx  <= '0;
      best_cnt  <= '0;
      best_addr <= '0;
      found     <= 1'b0;
      nrr_cmd   <= 1'b0;
      nrr_bank  <= '0;
      nrr_addr  <= '0;
      busy      <= 1'b0;
      rfm_drop  <= 1'b0;
      for (int b = 0; b < NUM_BANK; b++) raa[b] <= '0;
    end else begin
      nrr_cmd  <= 1'b0;
      rfm_drop <= 1'b0;
      for (int b = 0; b < NUM_BANK; b++) raa[b] <= raa_n[b];
      unique case (state)
        IDLE: begin
          if (rfm_cmd) begin
            state     <= SCAN;
            busy      <= 1'b1;
            scan_bank <= rfm_bank;
            idx       <= '0;
            best_idx  <= '0;
            best_cnt  <= '0;
            found     <= 1'b0;
          end
        end
        SCAN: begin
          rfm_drop <= rfm_cmd;
          if (take) begin
            best_cnt  <= cur_cnt;
            best_idx  <= idx;
            best_addr <= cur_addr;
            found     <= 1'b1;
          end
          if (idx == LAST) begin
            state <= ISSUE;
            if (found || take) begin
              nrr_cmd  <= 1'b1;
              nrr_bank <= scan_bank;
              nrr_addr <= take ? cur_addr : best_addr;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ISSUE: begin
          rfm_drop <= rfm_cmd;
          state    <= IDLE;
          busy     <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
